gate_unit_arbiter: RTL and testbench

- Shares one registered, opcode-selectable 2-input bitwise gate unit between NUM_REQ requesters. Supported operations are NOR, AND, OR and XOR.
- Requester selection is round-robin, with a valid/ready handshake on each requester.
- The result goes into a single-entry output buffer that supports backpressure.
- The block sits between training-lab stimulus sources and the shared gate datapath, and serialises their operations.

---
 rtl/gate_pkg.sv | 22 ++
 rtl/gate_unit_arbiter_rr_arbiter.sv | 33 +++
 rtl/gate_unit_arbiter.sv | 88 ++++++++
 tb/tb_gate_unit_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared opcode encoding and single-bit gate evaluation for the gate unit arbiter.
package gate_pkg;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } opcode_t;

  function automatic logic gate_eval(opcode_t op, logic a, logic b);
    logic r;
    case (op)
      OP_NOR:  r = ~(a | b);
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_unit_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 enable,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int unsigned NU = N;
  localparam int IW = $clog2(N);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NU; k++) begin
      idx = (32'(ptr) + k) % NU;
      if (!found && enable && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin sharing of one registered bitwise gate unit behind a single-entry output buffer.
module gate_unit_arbiter
  import gate_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [2*NUM_REQ-1:0]       req_op,
  input  logic [WIDTH*NUM_REQ-1:0]   req_a,
  input  logic [WIDTH*NUM_REQ-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [CNT_W-1:0]           grant_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]         state;
  logic [ID_W-1:0]    ptr;
  logic               can_accept;
  logic               accept;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [WIDTH-1:0]   result;
  opcode_t            op_sel;
  int unsigned        sel;

  // Reset gating keeps req_ready low while rst_n is held, even though the buffer reads EMPTY.
  assign can_accept = rst_n && ((state == ST_EMPTY) || rsp_ready);

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .enable    (can_accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign rsp_valid = (state == ST_FULL);

  always_comb begin
    sel    = 32'(grant_idx);
    a_sel  = req_a[sel*WIDTH +: WIDTH];
    b_sel  = req_b[sel*WIDTH +: WIDTH];
    op_sel = opcode_t'(req_op[2*sel +: 2]);
    result = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      result[i] = gate_eval(op_sel, a_sel[i], b_sel[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      ptr         <= '0;
      rsp_data    <= '0;
      rsp_id      <= '0;
      grant_count <= '0;
    end else if (accept) begin
      state    <= ST_FULL;
      rsp_data <= result;
      rsp_id   <= grant_idx;
      ptr      <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      if (grant_count != '1) begin
        grant_count <= grant_count + 1'b1;
      end
    end else if ((state == ST_FULL) && rsp_ready) begin
      state <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed self-checking bench for gate_unit_arbiter, plus a CNT_W=4 instance for saturation.
module tb_gate_unit_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic [15:0] grant_count;

  logic [3:0]  s_req_valid;
  logic [3:0]  s_req_ready;
  logic        s_rsp_valid;
  logic        s_rsp_ready;
  logic [7:0]  s_rsp_data;
  logic [1:0]  s_rsp_id;
  logic [3:0]  s_grant_count;

  int checks;
  int errors;

  gate_unit_arbiter #(.NUM_REQ(4), .WIDTH(8), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .grant_count (grant_count)
  );

  gate_unit_arbiter #(.NUM_REQ(4), .WIDTH(8), .CNT_W(4)) dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (s_req_valid),
    .req_ready   (s_req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (s_rsp_valid),
    .rsp_ready   (s_rsp_ready),
    .rsp_data    (s_rsp_data),
    .rsp_id      (s_rsp_id),
    .grant_count (s_grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0 || grant_count !== 16'd0 || rsp_data !== 8'h00 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b cnt=%0d d=%h id=%0d exp 0/0/00/0",
               rsp_valid, grant_count, rsp_data, rsp_id);
    end
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_op_sweep();
    logic [7:0] exp_data [4];
    exp_data[0] = 8'h03; exp_data[1] = 8'hC0; exp_data[2] = 8'hFC; exp_data[3] = 8'h3C;
    tick();
    rsp_ready = 1'b1;
    req_a[23:16] = 8'hF0;
    req_b[23:16] = 8'hCC;
    req_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      req_op[5:4] = 2'(k);
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
        errors++; $display("FAIL sweep_ready op=%0d got=%b exp=0100", k, req_ready);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_data[k] || rsp_id !== 2'd2) begin
        errors++;
        $display("FAIL sweep_result op=%0d got v=%b d=%h id=%0d exp v=1 d=%h id=2",
                 k, rsp_valid, rsp_data, rsp_id, exp_data[k]);
      end
    end
    req_valid = 4'b0000;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || grant_count !== 16'd4) begin
      errors++; $display("FAIL sweep_drain got v=%b cnt=%0d exp v=0 cnt=4", rsp_valid, grant_count);
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b1111;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL mid_setup got v=%b id=%0d rdy=%b exp v=1 id=0 rdy=0000", rsp_valid, rsp_id, req_ready);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || grant_count !== 16'd0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset got v=%b cnt=%0d rdy=%b exp v=0 cnt=0 rdy=0000",
               rsp_valid, grant_count, req_ready);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_release got rdy=%b v=%b exp rdy=0001 v=0", req_ready, rsp_valid);
    end
    req_valid = 4'b0000;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || grant_count !== 16'd0) begin
      errors++; $display("FAIL mid_no_rsp got v=%b cnt=%0d exp v=0 cnt=0", rsp_valid, grant_count);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_data [4];
    exp_data[0] = 8'h50; exp_data[1] = 8'h05; exp_data[2] = 8'hAF; exp_data[3] = 8'hAA;
    req_op    = 8'b11_10_01_00;
    req_a     = {4{8'hA5}};
    req_b     = {4{8'h0F}};
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL rr_first got=%b exp=0001", req_ready);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(i % 4) || rsp_data !== exp_data[i % 4]) begin
        errors++;
        $display("FAIL rr_seq step=%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h",
                 i, rsp_valid, rsp_id, rsp_data, i % 4, exp_data[i % 4]);
      end
    end
    checks++;
    if (grant_count !== 16'd8) begin
      errors++; $display("FAIL rr_count got=%0d exp=8", grant_count);
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_data !== 8'h05 || rsp_id !== 2'd1) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b d=%h id=%0d exp rdy=0000 v=1 d=05 id=1",
                 i, req_ready, rsp_valid, rsp_data, rsp_id);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL bp_release_ready got=%b exp=0100", req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'hAF || grant_count !== 16'd10) begin
      errors++;
      $display("FAIL bp_refill got v=%b id=%0d d=%h cnt=%0d exp v=1 id=2 d=AF cnt=10",
               rsp_valid, rsp_id, rsp_data, grant_count);
    end
    req_valid = 4'b0000;
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain got v=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_skip_wrap();
    logic [1:0] exp_id [3];
    logic [3:0] exp_rdy [3];
    exp_id[0] = 2'd3; exp_id[1] = 2'd1; exp_id[2] = 2'd3;
    exp_rdy[0] = 4'b1000; exp_rdy[1] = 4'b0010; exp_rdy[2] = 4'b1000;
    // Pointer is 3 here; a grant to requester 1 moves it to 2.
    req_valid = 4'b0010;
    tick();
    checks++;
    if (rsp_id !== 2'd1) begin
      errors++; $display("FAIL skip_setup got id=%0d exp=1", rsp_id);
    end
    req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req_ready !== exp_rdy[i]) begin
        errors++; $display("FAIL skip_ready step=%0d got=%b exp=%b", i, req_ready, exp_rdy[i]);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id[i]) begin
        errors++;
        $display("FAIL skip_grant step=%0d got v=%b id=%0d exp v=1 id=%0d", i, rsp_valid, rsp_id, exp_id[i]);
      end
    end
    req_valid = 4'b0000;
    tick();
    checks++;
    if (grant_count !== 16'd14) begin
      errors++; $display("FAIL skip_count got=%0d exp=14", grant_count);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_cnt;
    s_rsp_ready = 1'b1;
    s_req_valid = 4'b0001;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_cnt = (i > 15) ? 4'hF : 4'(i);
      checks++;
      if (s_grant_count !== exp_cnt || s_rsp_valid !== 1'b1 || s_rsp_id !== 2'd0) begin
        errors++;
        $display("FAIL sat_count n=%0d got cnt=%h v=%b id=%0d exp cnt=%h v=1 id=0",
                 i, s_grant_count, s_rsp_valid, s_rsp_id, exp_cnt);
      end
    end
    checks++;
    if (s_rsp_data !== 8'h50 || s_req_ready !== 4'b0001) begin
      errors++; $display("FAIL sat_data got d=%h rdy=%b exp d=50 rdy=0001", s_rsp_data, s_req_ready);
    end
    s_req_valid = 4'b0000;
    tick();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    req_valid   = '0;
    req_op      = '0;
    req_a       = '0;
    req_b       = '0;
    rsp_ready   = 1'b0;
    s_req_valid = '0;
    s_rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_op_sweep();
    test_reset_mid();
    test_round_robin();
    test_backpressure();
    test_skip_wrap();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
